j1_io_bridge: RTL

- Sits between the j1 core's I/O pins and the peripheral write bus.
- Filters the core's raw io_rd/io_wr strobes down to true I/O space (addr[15:14] != 0) and decodes a local status register.
- Buffers core writes in a posted-write FIFO, because the core cannot stall.
- Arbitrates round-robin between that FIFO and a second host/DMA write requester for one registered valid/ready peripheral write port.

---
 rtl/j1_io_bridge_if.sv | 36 +++
 rtl/j1_io_bridge.sv | 137 +++++++++++++
 2 files changed

// File: rtl/j1_io_bridge_if.sv
// Bus bundle around the j1 I/O bridge: core I/O pins, peripheral read
// path, host write requester and the registered peripheral write port.
// The bridge uses the slave view; the core, host and peripherals use master.
interface j1_io_bridge_if;
    logic        cpu_io_rd;
    logic        cpu_io_wr;
    logic [15:0] cpu_io_addr;
    logic [15:0] cpu_io_dout;
    logic [15:0] cpu_io_din;
    logic        rd_strobe;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        host_valid;
    logic        host_ready;
    logic [15:0] host_addr;
    logic [15:0] host_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_src;

    modport slave (
        input  cpu_io_rd, cpu_io_wr, cpu_io_addr, cpu_io_dout, rd_data,
               host_valid, host_addr, host_data, wr_ready,
        output cpu_io_din, rd_strobe, rd_addr, host_ready,
               wr_valid, wr_addr, wr_data, wr_src
    );

    modport master (
        output cpu_io_rd, cpu_io_wr, cpu_io_addr, cpu_io_dout, rd_data,
               host_valid, host_addr, host_data, wr_ready,
        input  cpu_io_din, rd_strobe, rd_addr, host_ready,
               wr_valid, wr_addr, wr_data, wr_src
    );
endinterface

// File: rtl/j1_io_bridge.sv
// j1 I/O bridge: qualifies core I/O strobes, exposes a status register,
// posts core writes into a FIFO and round-robins that FIFO against a host
// requester onto one registered valid/ready peripheral write port.
module j1_io_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] STAT_ADDR  = 16'hFFFE
) (
    input logic           sys_clk_i,
    input logic           sys_rst_i,
    j1_io_bridge_if.slave bus
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;
    typedef enum logic {GRANT_CPU = 1'b0, GRANT_HOST = 1'b1} grant_t;

    localparam lvl_t FULL_LVL = lvl_t'(FIFO_DEPTH);

    logic [15:0] r_mem_addr [FIFO_DEPTH];
    logic [15:0] r_mem_data [FIFO_DEPTH];
    ptr_t        r_wptr;
    ptr_t        r_rptr;
    lvl_t        r_level;
    logic        r_ovf;
    grant_t      r_last;
    logic        r_wr_valid;
    logic        r_wr_src;
    logic [15:0] r_wr_addr;
    logic [15:0] r_wr_data;

    logic        w_io_space;
    logic        w_is_stat;
    logic [15:0] w_status;
    logic        w_push_req;
    logic        w_full;
    logic        w_fifo_req;
    logic        w_stage_free;
    logic        w_grant_cpu;
    logic        w_grant_host;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_ovf_clr;

    // Address decode and zero-latency read path
    assign w_io_space = (bus.cpu_io_addr[15:14] != 2'b00);
    assign w_is_stat  = w_io_space && (bus.cpu_io_addr == STAT_ADDR);
    assign w_status   = {r_ovf, 10'b0, 5'(r_level)};

    assign bus.cpu_io_din = w_is_stat ? w_status : bus.rd_data;
    assign bus.rd_strobe  = bus.cpu_io_rd && w_io_space && !w_is_stat;
    assign bus.rd_addr    = bus.cpu_io_addr;

    // Arbitration: reset is folded into stage_free so host_ready stays low
    // while the bridge is held in reset.
    assign w_fifo_req   = (r_level != '0);
    assign w_stage_free = !sys_rst_i && (!r_wr_valid || bus.wr_ready);
    assign w_grant_cpu  = w_stage_free && w_fifo_req &&
                          (!bus.host_valid || (r_last == GRANT_HOST));
    assign w_grant_host = w_stage_free && bus.host_valid &&
                          (!w_fifo_req || (r_last == GRANT_CPU));
    assign w_pop        = w_grant_cpu;

    assign bus.host_ready = w_grant_host;

    // Posted-write FIFO control
    assign w_push_req = bus.cpu_io_wr && w_io_space && !w_is_stat;
    assign w_full     = (r_level == FULL_LVL);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = bus.cpu_io_wr && w_is_stat;

    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.wr_src   = r_wr_src;

    // FIFO storage; contents need no reset since the level gates every read
    always_ff @(posedge sys_clk_i) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= bus.cpu_io_addr;
            r_mem_data[r_wptr] <= bus.cpu_io_dout;
        end
    end

    // FIFO pointers, level, sticky overflow, output stage and last-grant
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_src   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_last     <= GRANT_HOST;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ptr_t'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + lvl_t'(1);
                2'b01:   r_level <= r_level - lvl_t'(1);
                default: r_level <= r_level;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_stage_free) begin
                if (w_grant_cpu) begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_mem_addr[r_rptr];
                    r_wr_data  <= r_mem_data[r_rptr];
                    r_wr_src   <= 1'b0;
                    r_last     <= GRANT_CPU;
                end else if (w_grant_host) begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= bus.host_addr;
                    r_wr_data  <= bus.host_data;
                    r_wr_src   <= 1'b1;
                    r_last     <= GRANT_HOST;
                end else begin
                    r_wr_valid <= 1'b0;
                end
            end
        end
    end

endmodule
